af_gram_accum: RTL and testbench

// - Per-frequency Gram-matrix engine G = A^H*A for the inverse pipeline; A is MIC_NUM x SOR_NUM complex per bin.
// - Reads A from the AF BRAM, writes the upper triangle of G (optionally diagonal-loaded) to the result BRAM.
// - Generalises the fixed 8x2 datapath: any SOR_NUM, selectable BRAM read latency, diagonal-loading mode.
// - One start per bin; internal bin counter sweeps 0..FREQ_NUM-1 and wraps.

---
 rtl/af_gram_accum_pkg.sv | 31 +++
 rtl/af_gram_accum_mac.sv | 80 ++++++++
 rtl/af_gram_accum.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_af_gram_accum.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/af_gram_accum_pkg.sv
// Shared types and elaboration helpers for the Gram-matrix accumulator.
package af_gram_accum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Ceiling log2, zero for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Number of upper-triangle entries of an s x s Gram matrix.
  function automatic int pair_count(input int s);
    return (s * (s + 1)) / 2;
  endfunction

endpackage

// File: rtl/af_gram_accum_mac.sv
// Complex conjugate multiply-accumulate: acc += conj(a) * b with one registered product stage.
module af_gram_accum_mac #(
  parameter int DW = 16,
  parameter int AW = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  output logic [AW-1:0] acc_re,
  output logic [AW-1:0] acc_im
);

  localparam int PW = 2 * DW + 1;

  logic signed [2*DW-1:0] rr_s, ii_s, ri_s, ir_s;
  logic [PW-1:0] p_re_d, p_re_q, p_im_d, p_im_q;
  logic          p_vld_d, p_vld_q;
  logic [AW-1:0] acc_re_d, acc_re_q, acc_im_d, acc_im_q;

  // Partial products and next-state of product/accumulator registers.
  always_comb begin
    rr_s = $signed({{DW{a_re[DW-1]}}, a_re}) * $signed({{DW{b_re[DW-1]}}, b_re});
    ii_s = $signed({{DW{a_im[DW-1]}}, a_im}) * $signed({{DW{b_im[DW-1]}}, b_im});
    ri_s = $signed({{DW{a_re[DW-1]}}, a_re}) * $signed({{DW{b_im[DW-1]}}, b_im});
    ir_s = $signed({{DW{a_im[DW-1]}}, a_im}) * $signed({{DW{b_re[DW-1]}}, b_re});
    p_re_d   = p_re_q;
    p_im_d   = p_im_q;
    p_vld_d  = p_vld_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (clr) begin
      p_vld_d  = 1'b0;
      acc_re_d = '0;
      acc_im_d = '0;
    end else begin
      p_vld_d = en;
      if (en) begin
        // conj(a)*b: real = ar*br + ai*bi, imag = ar*bi - ai*br
        p_re_d = {rr_s[2*DW-1], rr_s} + {ii_s[2*DW-1], ii_s};
        p_im_d = {ri_s[2*DW-1], ri_s} - {ir_s[2*DW-1], ir_s};
      end else begin
        p_re_d = p_re_q;
        p_im_d = p_im_q;
      end
      if (p_vld_q) begin
        acc_re_d = acc_re_q + {{(AW-PW){p_re_q[PW-1]}}, p_re_q};
        acc_im_d = acc_im_q + {{(AW-PW){p_im_q[PW-1]}}, p_im_q};
      end else begin
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
      end
    end
  end

  // Product and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_re_q   <= '0;
      p_im_q   <= '0;
      p_vld_q  <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      p_re_q   <= p_re_d;
      p_im_q   <= p_im_d;
      p_vld_q  <= p_vld_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  end

  assign acc_re = acc_re_q;
  assign acc_im = acc_im_q;

endmodule

// File: rtl/af_gram_accum.sv
// Per-bin Gram matrix G = A^H*A: loads A from the AF BRAM, writes the upper triangle of G.
module af_gram_accum
  import af_gram_accum_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int ACC_WIDTH          = 48,
  parameter int MIC_NUM            = 8,
  parameter int SOR_NUM            = 2,
  parameter int FREQ_NUM           = 257,
  parameter int RD_LAT             = 1,
  parameter int BRAM_RD_ADDR_WIDTH = 32,
  parameter int BRAM_WR_ADDR_WIDTH = 32,
  parameter int BRAM_RD_ADDR_BASE  = 0,
  parameter int BRAM_WR_ADDR_BASE  = 0,
  parameter int BRAM_RD_INCREASE   = 2,
  parameter int BRAM_WR_INCREASE   = 6,
  parameter int BRAM_WR_WE_WIDTH   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          load_en,
  input  logic [DATA_WIDTH-1:0]         load_val,
  input  logic [DATA_WIDTH-1:0]         af_bram_rd_real,
  input  logic [DATA_WIDTH-1:0]         af_bram_rd_imag,
  output logic [BRAM_RD_ADDR_WIDTH-1:0] bram_rd_addr,
  output logic [ACC_WIDTH-1:0]          result_bram_wr_real,
  output logic [ACC_WIDTH-1:0]          result_bram_wr_imag,
  output logic [BRAM_WR_ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [BRAM_WR_WE_WIDTH-1:0]   bram_wr_we,
  output logic                          bram_wr_en,
  output logic                          busy,
  output logic                          done,
  output logic                          all_freq_finish
);

  localparam int NW    = MIC_NUM * SOR_NUM;
  localparam int U     = pair_count(SOR_NUM);
  localparam int IDX_W = (clog2(NW) < 1) ? 1 : clog2(NW);
  localparam int CNT_W = clog2(NW + MIC_NUM + 2) + 1;
  localparam int SW    = clog2(SOR_NUM) + 1;
  localparam int KW    = clog2(U) + 1;
  localparam int BW    = clog2(FREQ_NUM) + 1;
  localparam bit LAT1  = (RD_LAT == 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(NW + RD_LAT - 1);
  localparam logic [CNT_W-1:0] NW_LAST   = CNT_W'(NW - 1);
  localparam logic [CNT_W-1:0] MAC_LAST  = CNT_W'(MIC_NUM);
  localparam logic [SW-1:0]    SOR_LAST  = SW'(SOR_NUM - 1);
  localparam logic [BW-1:0]    BIN_LAST  = BW'(FREQ_NUM - 1);

  if (RD_LAT != 0 && RD_LAT != 1) begin : g_bad_rd_lat
    $error("af_gram_accum: RD_LAT must be 0 or 1");
  end
  if (ACC_WIDTH < 2 * DATA_WIDTH + 1 + clog2(MIC_NUM)) begin : g_bad_acc_width
    $error("af_gram_accum: ACC_WIDTH too narrow for a full-precision sum");
  end

  state_t                          state_d, state_q;
  logic [CNT_W-1:0]                cnt_d, cnt_q;
  logic [SW-1:0]                   pi_d, pi_q, pj_d, pj_q;
  logic [KW-1:0]                   k_d, k_q;
  logic [BW-1:0]                   bin_d, bin_q;
  logic                            busy_d, busy_q, done_d, done_q, aff_d, aff_q;
  logic                            lden_d, lden_q;
  logic [DATA_WIDTH-1:0]           ldval_d, ldval_q;
  logic [BRAM_RD_ADDR_WIDTH-1:0]   rd_addr_d, rd_addr_q;
  logic [BRAM_WR_ADDR_WIDTH-1:0]   wr_addr_d, wr_addr_q;
  logic [ACC_WIDTH-1:0]            wr_re_d, wr_re_q, wr_im_d, wr_im_q;
  logic                            wr_en_d, wr_en_q;
  logic [BRAM_WR_WE_WIDTH-1:0]     we_d, we_q;
  logic [DATA_WIDTH-1:0]           sbuf_re_d [NW];
  logic [DATA_WIDTH-1:0]           sbuf_re_q [NW];
  logic [DATA_WIDTH-1:0]           sbuf_im_d [NW];
  logic [DATA_WIDTH-1:0]           sbuf_im_q [NW];
  logic [IDX_W-1:0]                cap_idx_s, idx_i_s, idx_j_s;
  logic                            diag_s;
  logic                            mac_clr_s, mac_en_s;
  logic [DATA_WIDTH-1:0]           mac_a_re_s, mac_a_im_s, mac_b_re_s, mac_b_im_s;
  logic [ACC_WIDTH-1:0]            acc_re_s, acc_im_s;

  function automatic logic [BRAM_RD_ADDR_WIDTH-1:0] rd_addr_of(input logic [BW-1:0] b,
                                                               input logic [CNT_W-1:0] c);
    return BRAM_RD_ADDR_WIDTH'(BRAM_RD_ADDR_BASE) +
           (BRAM_RD_ADDR_WIDTH'(b) * BRAM_RD_ADDR_WIDTH'(NW) + BRAM_RD_ADDR_WIDTH'(c)) *
           BRAM_RD_ADDR_WIDTH'(BRAM_RD_INCREASE);
  endfunction

  function automatic logic [BRAM_WR_ADDR_WIDTH-1:0] wr_addr_of(input logic [BW-1:0] b,
                                                               input logic [KW-1:0] k);
    return BRAM_WR_ADDR_WIDTH'(BRAM_WR_ADDR_BASE) +
           (BRAM_WR_ADDR_WIDTH'(b) * BRAM_WR_ADDR_WIDTH'(U) + BRAM_WR_ADDR_WIDTH'(k)) *
           BRAM_WR_ADDR_WIDTH'(BRAM_WR_INCREASE);
  endfunction

  af_gram_accum_mac #(.DW(DATA_WIDTH), .AW(ACC_WIDTH)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr_s),
    .en     (mac_en_s),
    .a_re   (mac_a_re_s),
    .a_im   (mac_a_im_s),
    .b_re   (mac_b_re_s),
    .b_im   (mac_b_im_s),
    .acc_re (acc_re_s),
    .acc_im (acc_im_s)
  );

  // Sequencer: next state, counters, sample buffer and registered BRAM/status outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pi_d      = pi_q;
    pj_d      = pj_q;
    k_d       = k_q;
    bin_d     = bin_q;
    busy_d    = busy_q;
    done_d    = done_q;
    aff_d     = aff_q;
    lden_d    = lden_q;
    ldval_d   = ldval_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_re_d   = wr_re_q;
    wr_im_d   = wr_im_q;
    wr_en_d   = 1'b0;
    we_d      = '0;
    sbuf_re_d = sbuf_re_q;
    sbuf_im_d = sbuf_im_q;
    cap_idx_s = '0;
    idx_i_s   = '0;
    idx_j_s   = '0;
    diag_s    = (pi_q == pj_q);
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    mac_a_re_s = '0;
    mac_a_im_s = '0;
    mac_b_re_s = '0;
    mac_b_im_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          aff_d     = 1'b0;
          lden_d    = load_en;
          ldval_d   = load_val;
          cnt_d     = '0;
          pi_d      = '0;
          pj_d      = '0;
          k_d       = '0;
          rd_addr_d = rd_addr_of(bin_q, '0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        mac_clr_s = 1'b1;
        // With a registered BRAM the data trails its address by one cycle.
        if (LAT1) begin
          cap_idx_s = IDX_W'(cnt_q - CNT_W'(1));
        end else begin
          cap_idx_s = IDX_W'(cnt_q);
        end
        if (!LAT1 || (cnt_q != '0)) begin
          sbuf_re_d[cap_idx_s] = af_bram_rd_real;
          sbuf_im_d[cap_idx_s] = af_bram_rd_imag;
        end else begin
          sbuf_re_d = sbuf_re_q;
          sbuf_im_d = sbuf_im_q;
        end
        if (cnt_q < NW_LAST) begin
          rd_addr_d = rd_addr_of(bin_q, cnt_q + CNT_W'(1));
        end else begin
          rd_addr_d = rd_addr_q;
        end
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_CALC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CALC: begin
        // Cycles 0..MIC_NUM-1 feed rows; the final cycle drains the product stage.
        if (cnt_q < MAC_LAST) begin
          mac_en_s   = 1'b1;
          idx_i_s    = IDX_W'(cnt_q) * IDX_W'(SOR_NUM) + IDX_W'(pi_q);
          idx_j_s    = IDX_W'(cnt_q) * IDX_W'(SOR_NUM) + IDX_W'(pj_q);
          mac_a_re_s = sbuf_re_q[idx_i_s];
          mac_a_im_s = sbuf_im_q[idx_i_s];
          mac_b_re_s = sbuf_re_q[idx_j_s];
          mac_b_im_s = sbuf_im_q[idx_j_s];
        end else begin
          mac_en_s = 1'b0;
        end
        if (cnt_q == MAC_LAST) begin
          state_d = ST_WR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR: begin
        mac_clr_s = 1'b1;
        wr_en_d   = 1'b1;
        we_d      = '1;
        wr_addr_d = wr_addr_of(bin_q, k_q);
        if (diag_s && lden_q) begin
          wr_re_d = acc_re_s + {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, ldval_q};
        end else begin
          wr_re_d = acc_re_s;
        end
        if (diag_s) begin
          wr_im_d = '0;
        end else begin
          wr_im_d = acc_im_s;
        end
        k_d = k_q + KW'(1);
        if (pj_q == SOR_LAST) begin
          if (pi_q == SOR_LAST) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_CALC;
            pi_d    = pi_q + SW'(1);
            pj_d    = pi_q + SW'(1);
          end
        end else begin
          state_d = ST_CALC;
          pj_d    = pj_q + SW'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (bin_q == BIN_LAST) begin
          aff_d = 1'b1;
          bin_d = '0;
        end else begin
          bin_d = bin_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any bin in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pi_q      <= '0;
      pj_q      <= '0;
      k_q       <= '0;
      bin_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aff_q     <= 1'b0;
      lden_q    <= 1'b0;
      ldval_q   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_re_q   <= '0;
      wr_im_q   <= '0;
      wr_en_q   <= 1'b0;
      we_q      <= '0;
      for (int i = 0; i < NW; i++) begin
        sbuf_re_q[i] <= '0;
        sbuf_im_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pi_q      <= pi_d;
      pj_q      <= pj_d;
      k_q       <= k_d;
      bin_q     <= bin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aff_q     <= aff_d;
      lden_q    <= lden_d;
      ldval_q   <= ldval_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_re_q   <= wr_re_d;
      wr_im_q   <= wr_im_d;
      wr_en_q   <= wr_en_d;
      we_q      <= we_d;
      sbuf_re_q <= sbuf_re_d;
      sbuf_im_q <= sbuf_im_d;
    end
  end

  assign bram_rd_addr        = rd_addr_q;
  assign result_bram_wr_real = wr_re_q;
  assign result_bram_wr_imag = wr_im_q;
  assign bram_wr_addr        = wr_addr_q;
  assign bram_wr_we          = we_q;
  assign bram_wr_en          = wr_en_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign all_freq_finish     = aff_q;

endmodule

// File: tb/tb_af_gram_accum.sv
// Randomised bench for af_gram_accum against a plain-arithmetic Gram-matrix model.
module tb_af_gram_accum;

  localparam int FREQ = 257;
  localparam int MIC  = 8;
  localparam int SOR  = 2;
  localparam int NW   = MIC * SOR;
  localparam int U    = 3;

  typedef struct {
    longint addr;
    longint re;
    longint im;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1, load_en;
  logic [15:0] load_val;
  logic [15:0] rd0_re, rd0_im, rd1_re, rd1_im;
  logic [31:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [47:0] wr_re0, wr_im0, wr_re1, wr_im1;
  logic [5:0]  we0, we1;
  logic        wr_en0, wr_en1, busy0, busy1, done0, done1, aff0, aff1;

  logic signed [15:0] mem_re [FREQ*NW];
  logic signed [15:0] mem_im [FREQ*NW];
  wr_t exp_q0[$];
  wr_t exp_q1[$];
  int  bin_m [2];
  int  n_cmp = 0;
  int  n_bad = 0;

  af_gram_accum #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .load_en(load_en), .load_val(load_val),
    .af_bram_rd_real(rd1_re), .af_bram_rd_imag(rd1_im), .bram_rd_addr(rd_addr1),
    .result_bram_wr_real(wr_re1), .result_bram_wr_imag(wr_im1), .bram_wr_addr(wr_addr1),
    .bram_wr_we(we1), .bram_wr_en(wr_en1), .busy(busy1), .done(done1), .all_freq_finish(aff1)
  );

  af_gram_accum #(.RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .load_en(load_en), .load_val(load_val),
    .af_bram_rd_real(rd0_re), .af_bram_rd_imag(rd0_im), .bram_rd_addr(rd_addr0),
    .result_bram_wr_real(wr_re0), .result_bram_wr_imag(wr_im0), .bram_wr_addr(wr_addr0),
    .bram_wr_we(we0), .bram_wr_en(wr_en0), .busy(busy0), .done(done0), .all_freq_finish(aff0)
  );

  function automatic logic [15:0] mem_rd(input logic [31:0] a, input bit imag);
    int w;
    w = int'(a >> 1);
    if (w < FREQ * NW) return imag ? mem_im[w] : mem_re[w];
    return 16'h0000;
  endfunction

  // AF BRAM models: registered read for the RD_LAT=1 DUT, combinational for RD_LAT=0.
  always @(posedge clk) begin
    rd1_re <= mem_rd(rd_addr1, 1'b0);
    rd1_im <= mem_rd(rd_addr1, 1'b1);
  end
  always_comb begin
    rd0_re = mem_rd(rd_addr0, 1'b0);
    rd0_im = mem_rd(rd_addr0, 1'b1);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int d); return (d == 1) ? busy1 : busy0; endfunction
  function automatic logic done_of(input int d); return (d == 1) ? done1 : done0; endfunction
  function automatic logic aff_of(input int d);  return (d == 1) ? aff1 : aff0;   endfunction
  function automatic int   qsize(input int d);   return (d == 1) ? exp_q1.size() : exp_q0.size(); endfunction

  // Reference: G[i][j] = sum_m conj(A[m][i]) * A[m][j], upper triangle in (i,j) order.
  task automatic push_bin(input int d, input int f, input logic le, input logic [15:0] lv);
    int  k;
    wr_t e;
    k = 0;
    for (int i = 0; i < SOR; i++) begin
      for (int j = i; j < SOR; j++) begin
        e.re = 0;
        e.im = 0;
        for (int m = 0; m < MIC; m++) begin
          longint ar, ai, br, bi;
          ar = longint'(mem_re[f*NW + m*SOR + i]);
          ai = longint'(mem_im[f*NW + m*SOR + i]);
          br = longint'(mem_re[f*NW + m*SOR + j]);
          bi = longint'(mem_im[f*NW + m*SOR + j]);
          e.re += ar * br + ai * bi;
          e.im += ar * bi - ai * br;
        end
        if (i == j) begin
          e.im = 0;
          if (le) e.re += longint'(lv);
        end
        e.addr = longint'((f * U + k) * 6);
        k++;
        if (d == 1) exp_q1.push_back(e); else exp_q0.push_back(e);
      end
    end
  endtask

  task automatic mon_wr(input int d, input logic [31:0] a, input logic [47:0] re,
                        input logic [47:0] im, input logic [5:0] we);
    wr_t e;
    chk("wr_pending", longint'(qsize(d) > 0), 1);
    if (qsize(d) > 0) begin
      if (d == 1) e = exp_q1.pop_front(); else e = exp_q0.pop_front();
      chk("wr_addr", longint'(a), e.addr);
      chk("wr_real", longint'($signed(re)), e.re);
      chk("wr_imag", longint'($signed(im)), e.im);
      chk("wr_we", longint'(we), 63);
    end
  endtask

  // Write monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en1 === 1'b1) mon_wr(1, wr_addr1, wr_re1, wr_im1, we1);
    if (wr_en0 === 1'b1) mon_wr(0, wr_addr0, wr_re0, wr_im0, we0);
  end

  task automatic run_bin(input int d, input logic le, input logic [15:0] lv,
                         input int lat, input bit poke);
    int n;
    bit got;
    @(negedge clk);
    load_en  = le;
    load_val = lv;
    if (d == 1) start1 = 1'b1; else start0 = 1'b1;
    push_bin(d, bin_m[d], le, lv);
    @(posedge clk);
    #1;
    start0   = 1'b0;
    start1   = 1'b0;
    load_en  = ~le;
    load_val = ~lv;
    chk("busy_on_start", longint'(busy_of(d)), 1);
    chk("done_drop", longint'(done_of(d)), 0);
    chk("aff_drop", longint'(aff_of(d)), 0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 10) begin
        if (d == 1) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      if (done_of(d)) got = 1'b1;
    end
    chk("done_latency", longint'(n), longint'(lat));
    chk("busy_at_done", longint'(busy_of(d)), 0);
    chk("aff_at_done", longint'(aff_of(d)), longint'(bin_m[d] == FREQ - 1));
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", longint'(done_of(d)), 1);
    chk("idle_after_done", longint'(busy_of(d)), 0);
    chk("writes_drained", longint'(qsize(d)), 0);
    bin_m[d] = (bin_m[d] + 1) % FREQ;
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; load_en = 1'b0; load_val = 16'h0000;
    bin_m[0] = 0;
    bin_m[1] = 0;
    for (int w = 0; w < FREQ * NW; w++) begin
      mem_re[w] = 16'($urandom);
      mem_im[w] = 16'($urandom);
    end
    for (int m = 0; m < MIC; m++) begin
      for (int s = 0; s < SOR; s++) begin
        mem_re[0*NW + m*SOR + s] = 16'sd1;     mem_im[0*NW + m*SOR + s] = 16'sd0;
        mem_re[1*NW + m*SOR + s] = 16'sd1;     mem_im[1*NW + m*SOR + s] = 16'sd0;
        mem_re[2*NW + m*SOR + s] = (s == 0) ? 16'sd1 : 16'sd0;
        mem_im[2*NW + m*SOR + s] = (s == 0) ? 16'sd0 : 16'sd1;
        mem_re[3*NW + m*SOR + s] = -16'sd32768; mem_im[3*NW + m*SOR + s] = -16'sd32768;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_addr", longint'(rd_addr1), 0);
    chk("rst_wr_addr", longint'(wr_addr1), 0);
    chk("rst_wr_real", longint'(wr_re1), 0);
    chk("rst_wr_imag", longint'(wr_im1), 0);
    chk("rst_we", longint'(we1), 0);
    chk("rst_wr_en", longint'(wr_en1), 0);
    chk("rst_busy", longint'(busy1), 0);
    chk("rst_done", longint'(done1), 0);
    chk("rst_aff", longint'(aff1), 0);
    chk("rst_rd_addr0", longint'(rd_addr0), 0);
    rst = 1'b0;

    run_bin(1, 1'b0, 16'd0,   48, 1'b0);
    run_bin(1, 1'b1, 16'd100, 48, 1'b0);
    run_bin(1, 1'b0, 16'd0,   48, 1'b0);
    run_bin(1, 1'b0, 16'd0,   48, 1'b1);
    for (int f = 4; f < FREQ; f++) begin
      run_bin(1, 1'($urandom), 16'($urandom), 48, 1'b0);
    end
    run_bin(1, 1'b1, 16'($urandom), 48, 1'b0);

    // Abort partway through the first pair's accumulation.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", longint'(busy1), 0);
    chk("abort_wr_en", longint'(wr_en1), 0);
    chk("abort_rd_addr", longint'(rd_addr1), 0);
    chk("abort_done", longint'(done1), 0);
    rst = 1'b0;
    bin_m[0] = 0;
    bin_m[1] = 0;
    repeat (60) @(posedge clk);
    #1;
    chk("abort_stays_idle", longint'(busy1), 0);
    run_bin(1, 1'b0, 16'd0, 48, 1'b0);

    for (int f = 0; f < 4; f++) begin
      run_bin(0, 1'($urandom), 16'($urandom), 47, (f == 1));
    end

    repeat (5) @(posedge clk);
    chk("final_q1_empty", longint'(exp_q1.size()), 0);
    chk("final_q0_empty", longint'(exp_q0.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
